// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types and helpers for the 7-segment scan controller.
// State encoding, blank code and index-width helper.
package seg_scan_pkg;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_e;

   localparam logic [3:0] BCD_BLANK = 4'hF;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// seg_scan_timer: loadable down-counter with terminal-count flag.
// Shared between the blank gap and the digit dwell interval.
module seg_scan_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear wins, then load, then count down to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - ONE;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scan with frame-aligned commit.
// Optional leading-zero blanking under `SEG_SCAN_LZB_EN.
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int DWELL_CYCLES = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   output logic [3:0]              bcd,
   output logic [NUM_DIGITS-1:0]   digit_en,
   output logic                    frame_done,
   output logic                    pending
);

   localparam int IW = idx_width(NUM_DIGITS);
   localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ?
                         DWELL_CYCLES : BLANK_CYCLES;
   localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] DWELL_LD = CW'(DWELL_CYCLES - 1);
   localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
   localparam logic [IW-1:0] IONE = IW'(1);

   state_e                  state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] cmt_q, cmt_d;
   logic [4*NUM_DIGITS-1:0] buf_q, buf_d;
   logic                    pending_q, pending_d;
   logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
   logic [3:0]              bcd_q, bcd_d;
   logic                    frame_done_q, frame_done_d;

   logic                    tmr_load;
   logic [CW-1:0]           tmr_val;
   logic                    tmr_tc;
   logic                    wrap;
   logic [NUM_DIGITS-1:0]   lz_mask;

   seg_scan_timer #(
      .W(CW)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (!enable),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tc       (tmr_tc)
   );

   // Scan sequencing: OFF -> BLANK -> SHOW per digit, wrap per frame.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      tmr_load = 1'b0;
      tmr_val  = BLANK_LD;
      wrap     = 1'b0;
      if (!enable) begin
         state_d = ST_OFF;
         idx_d   = '0;
      end else begin
         unique case (state_q)
            ST_OFF: begin
               state_d  = ST_BLANK;
               idx_d    = '0;
               tmr_load = 1'b1;
               tmr_val  = BLANK_LD;
            end
            ST_BLANK: begin
               if (tmr_tc) begin
                  state_d  = ST_SHOW;
                  tmr_load = 1'b1;
                  tmr_val  = DWELL_LD;
               end
            end
            ST_SHOW: begin
               if (tmr_tc) begin
                  state_d  = ST_BLANK;
                  tmr_load = 1'b1;
                  tmr_val  = BLANK_LD;
                  if (idx_q == LAST) begin
                     idx_d = '0;
                     wrap  = 1'b1;
                  end else begin
                     idx_d = idx_q + IONE;
                  end
               end
            end
            default: begin
               state_d = ST_OFF;
               idx_d   = '0;
            end
         endcase
      end
   end

   // Double buffer: loads park in buf, commit only at frame wrap.
   always_comb begin
      cmt_d     = cmt_q;
      buf_d     = buf_q;
      pending_d = pending_q;
      if (wrap) begin
         if (load) begin
            cmt_d = value;
         end else if (pending_q) begin
            cmt_d = buf_q;
         end
         pending_d = 1'b0;
      end else if (load) begin
         buf_d     = value;
         pending_d = 1'b1;
      end
   end

`ifdef SEG_SCAN_LZB_EN
   // Blank zeros that have only zeros above them; digit 0 always shows.
   always_comb begin : lzb
      logic zero_above;
      zero_above = 1'b1;
      lz_mask    = '0;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         if (zero_above && cmt_d[4*k +: 4] == 4'h0) begin
            lz_mask[k] = 1'b1;
         end else begin
            zero_above = 1'b0;
         end
      end
   end
`else
   assign lz_mask = '0;
`endif

   // Outputs are computed from next state so they can be registered.
   always_comb begin
      digit_en_d   = '0;
      bcd_d        = cmt_d[4*int'(idx_d) +: 4];
      frame_done_d = wrap;
      if (state_d == ST_SHOW) begin
         digit_en_d[idx_d] = 1'b1;
      end
      if (state_d == ST_OFF || lz_mask[idx_d]) begin
         bcd_d = BCD_BLANK;
      end
   end

   // State, buffers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_OFF;
         idx_q        <= '0;
         cmt_q        <= {NUM_DIGITS{BCD_BLANK}};
         buf_q        <= '0;
         pending_q    <= 1'b0;
         digit_en_q   <= '0;
         bcd_q        <= BCD_BLANK;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cmt_q        <= cmt_d;
         buf_q        <= buf_d;
         pending_q    <= pending_d;
         digit_en_q   <= digit_en_d;
         bcd_q        <= bcd_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bcd        = bcd_q;
   assign digit_en   = digit_en_q;
   assign frame_done = frame_done_q;
   assign pending    = pending_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench for seg_scan_ctrl (4 digits, 4/2 timing).
// Expected frames come from a per-cycle position model of the scan.
module tb_seg_scan_ctrl;

   localparam int ND = 4;
   localparam int DW = 4;
   localparam int BK = 2;
   localparam int DP = DW + BK;
   localparam int FP = ND * DP;

   logic          clk;
   logic          rst_n;
   logic          enable;
   logic          load;
   logic [15:0]   value;
   logic [3:0]    bcd;
   logic [ND-1:0] digit_en;
   logic          frame_done;
   logic          pending;

   int checks;
   int failures;

   seg_scan_ctrl #(
      .NUM_DIGITS   (ND),
      .DWELL_CYCLES (DW),
      .BLANK_CYCLES (BK)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .load       (load),
      .value      (value),
      .bcd        (bcd),
      .digit_en   (digit_en),
      .frame_done (frame_done),
      .pending    (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] exp_nib(input logic [15:0] v,
                                          input int d);
      logic [3:0] n;
      n = v[4*d +: 4];
`ifdef SEG_SCAN_LZB_EN
      begin
         bit z;
         z = 1'b1;
         for (int k = d; k < ND; k++) begin
            if (v[4*k +: 4] != 4'h0) z = 1'b0;
         end
         if (d != 0 && z) n = 4'hF;
      end
`endif
      return n;
   endfunction

   // Called at the negedge of frame cycle 0; checks ncyc cycles.
   task automatic run_frame(input logic [15:0] v,
                            input bit fd0,
                            input bit pend0,
                            input int lc1,
                            input logic [15:0] lv1,
                            input int lc2,
                            input logic [15:0] lv2,
                            input int ncyc);
      int d;
      int p;
      logic [31:0] en_exp;
      bit pe;
      for (int c = 0; c < ncyc; c++) begin
         d = c / DP;
         p = c % DP;
         en_exp = (p < BK) ? 32'd0 : (32'd1 << d);
         pe = pend0 || (lc1 >= 0 && c > lc1) ||
              (lc2 >= 0 && c > lc2);
         chk($sformatf("digit_en c%0d", c), 32'(digit_en), en_exp);
         chk($sformatf("bcd c%0d", c), 32'(bcd),
             32'(exp_nib(v, d)));
         chk($sformatf("frame_done c%0d", c), 32'(frame_done),
             (c == 0) ? 32'(fd0) : 32'd0);
         chk($sformatf("pending c%0d", c), 32'(pending), 32'(pe));
         load = 1'b0;
         if (c == lc1) begin
            load  = 1'b1;
            value = lv1;
         end
         if (c == lc2) begin
            load  = 1'b1;
            value = lv2;
         end
         @(negedge clk);
      end
      load = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      enable   = 1'b0;
      load     = 1'b0;
      value    = '0;
      repeat (2) @(negedge clk);
      chk("rst digit_en", 32'(digit_en), 32'd0);
      chk("rst bcd", 32'(bcd), 32'hF);
      chk("rst frame_done", 32'(frame_done), 32'd0);
      chk("rst pending", 32'(pending), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         chk("off digit_en", 32'(digit_en), 32'd0);
         chk("off bcd", 32'(bcd), 32'hF);
         chk("off frame_done", 32'(frame_done), 32'd0);
      end

      load  = 1'b1;
      value = 16'h1234;
      @(negedge clk);
      load = 1'b0;
      chk("off load pending", 32'(pending), 32'd1);
      enable = 1'b1;
      @(negedge clk);

      run_frame(16'hFFFF, 0, 1, -1, 0, -1, 0, FP);
      run_frame(16'h1234, 1, 0, 10, 16'h5678, -1, 0, FP);
      run_frame(16'h5678, 1, 0, 3, 16'h1111, 15, 16'h2222, FP);
      run_frame(16'h2222, 1, 0, FP - 1, 16'h0070, -1, 0, FP);
      run_frame(16'h0070, 1, 0, FP - 1, 16'h0000, -1, 0, FP);
      run_frame(16'h0000, 1, 0, -1, 0, -1, 0, FP);

      run_frame(16'h0000, 1, 0, -1, 0, -1, 0, 15);
      chk("drop pre digit_en", 32'(digit_en), 32'h4);
      enable = 1'b0;
      @(negedge clk);
      chk("drop digit_en", 32'(digit_en), 32'd0);
      chk("drop frame_done", 32'(frame_done), 32'd0);
      @(negedge clk);
      chk("drop2 digit_en", 32'(digit_en), 32'd0);
      enable = 1'b1;
      @(negedge clk);

      run_frame(16'h0000, 0, 0, 3, 16'h1234, -1, 0, 9);
      chk("pre rst digit_en", 32'(digit_en), 32'h2);
      rst_n = 1'b0;
      #1;
      chk("mid rst digit_en", 32'(digit_en), 32'd0);
      chk("mid rst bcd", 32'(bcd), 32'hF);
      chk("mid rst frame_done", 32'(frame_done), 32'd0);
      chk("mid rst pending", 32'(pending), 32'd0);
      enable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      enable = 1'b1;
      @(negedge clk);
      run_frame(16'hFFFF, 0, 0, -1, 0, -1, 0, FP);
      run_frame(16'hFFFF, 1, 0, -1, 0, -1, 0, FP);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
